tuner_sequencer: RTL and testbench

- Top-level controller for one tuner measurement: memory clear, sample load (load_to_mem), FFT (fft), then peak/note search (find_freq).
- Owns the single-port sample/spectrum memory and routes its address/write port to whichever stage is active.
- Supports single-shot and continuous measurement, with a per-stage watchdog.
- Replaces the ad-hoc state machine and memory mux in the tuner top; sits between the stage engines and mem, and feeds the stage code to display_result.

---
 rtl/tuner_pkg.sv | 44 ++++
 rtl/tuner_sequencer_watchdog.sv | 41 ++++
 rtl/tuner_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_tuner_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tuner_pkg.sv
// Shared types and constants for the tuner measurement path.
package tuner_pkg;

    // Default memory geometry, shared with mem, fft, find_freq and display_result.
    localparam int ADDR_W_DEF = 11;
    localparam int DATA_W_DEF = 10;

    // Sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_MEM_CLR = 3'd1,
        ST_LOAD    = 3'd2,
        ST_FFT     = 3'd3,
        ST_FREQ    = 3'd4,
        ST_DONE    = 3'd5,
        ST_GAP     = 3'd6,
        ST_ERR     = 3'd7
    } state_e;

    // Stage codes shown on the display.
    localparam logic [2:0] STG_IDLE = 3'd0;
    localparam logic [2:0] STG_LOAD = 3'd1;
    localparam logic [2:0] STG_FFT  = 3'd2;
    localparam logic [2:0] STG_FREQ = 3'd3;
    localparam logic [2:0] STG_DONE = 3'd4;
    localparam logic [2:0] STG_GAP  = 3'd5;
    localparam logic [2:0] STG_ERR  = 3'd7;

    // Map a state to its display code (IDLE and MEM_CLR both show 0).
    function automatic logic [2:0] stage_code(input state_e s);
        logic [2:0] c;
        case (s)
            ST_LOAD: c = STG_LOAD;
            ST_FFT:  c = STG_FFT;
            ST_FREQ: c = STG_FREQ;
            ST_DONE: c = STG_DONE;
            ST_GAP:  c = STG_GAP;
            ST_ERR:  c = STG_ERR;
            default: c = STG_IDLE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/tuner_sequencer_watchdog.sv
// Per-stage watchdog: counts cycles while enabled, flags the last allowed cycle.
module stage_watchdog #(
    parameter int STAGE_TIMEOUT = 600000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CNT_W = (STAGE_TIMEOUT > 2) ? $clog2(STAGE_TIMEOUT) : 1;
    // A stage may occupy at most STAGE_TIMEOUT-1 cycles; the count reads
    // STAGE_TIMEOUT-2 in the last of them (it would reach STAGE_TIMEOUT-1 next).
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STAGE_TIMEOUT - 2);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = en_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/tuner_sequencer.sv
// Tuner measurement sequencer: clear -> load -> fft -> find_freq, owns the
// sample/spectrum memory port and routes it to the active stage.
//
// Handshake: each stage start is a level held for the whole stage; the stage
// raises its done while start is high, and the sequencer moves on at the edge
// where it samples done=1. done seen outside its own stage is ignored.
module tuner_sequencer
    import tuner_pkg::*;
#(
    parameter int ADDR_W        = ADDR_W_DEF,
    parameter int DATA_W        = DATA_W_DEF,
    parameter int STAGE_TIMEOUT = 600000,
    parameter int IDLE_GAP      = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              single,
    input  logic              err_clr,
    output logic              load_start,
    output logic              fft_start,
    output logic              freq_start,
    input  logic              load_done,
    input  logic              fft_done,
    input  logic              freq_done,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [ADDR_W-1:0] fft_addr,
    input  logic [ADDR_W-1:0] freq_addr,
    input  logic [DATA_W-1:0] load_wdata,
    input  logic [DATA_W-1:0] fft_wdata,
    input  logic              load_we,
    input  logic              fft_we,
    output logic              mem_rst_n,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic [2:0]        stage,
    output logic              busy,
    output logic              result_valid,
    output logic              error,
    output logic [1:0]        err_stage
);

    localparam int GAP_W = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(IDLE_GAP - 1);

    state_e           state_q;
    logic [GAP_W-1:0] gap_q;
    logic             error_q;
    logic [1:0]       err_stage_q;

    logic in_stage;
    logic cur_done;
    logic wd_clr;
    logic wd_expire;

    // Done of the stage that currently owns the sequencer; other dones are ignored.
    always_comb begin
        cur_done = 1'b0;
        case (state_q)
            ST_LOAD: cur_done = load_done;
            ST_FFT:  cur_done = fft_done;
            ST_FREQ: cur_done = freq_done;
            default: cur_done = 1'b0;
        endcase
    end

    assign in_stage = (state_q == ST_LOAD) || (state_q == ST_FFT) || (state_q == ST_FREQ);
    // LOAD is only entered from MEM_CLR and FFT/FREQ only on the previous
    // stage's done, so these two terms cover every stage entry.
    assign wd_clr   = (state_q == ST_MEM_CLR) || (in_stage && cur_done);

    stage_watchdog #(
        .STAGE_TIMEOUT(STAGE_TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (wd_clr),
        .en_i     (in_stage),
        .expire_o (wd_expire)
    );

    // Main FSM with the gap counter and sticky error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            gap_q       <= '0;
            error_q     <= 1'b0;
            err_stage_q <= 2'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (single || run) begin
                        state_q <= ST_MEM_CLR;
                    end
                end
                ST_MEM_CLR: begin
                    state_q <= ST_LOAD;
                end
                ST_LOAD: begin
                    // done takes priority over a simultaneous watchdog expiry
                    if (load_done) begin
                        state_q <= ST_FFT;
                    end else if (wd_expire) begin
                        state_q     <= ST_ERR;
                        error_q     <= 1'b1;
                        err_stage_q <= STG_LOAD[1:0];
                    end
                end
                ST_FFT: begin
                    if (fft_done) begin
                        state_q <= ST_FREQ;
                    end else if (wd_expire) begin
                        state_q     <= ST_ERR;
                        error_q     <= 1'b1;
                        err_stage_q <= STG_FFT[1:0];
                    end
                end
                ST_FREQ: begin
                    if (freq_done) begin
                        state_q <= ST_DONE;
                    end else if (wd_expire) begin
                        state_q     <= ST_ERR;
                        error_q     <= 1'b1;
                        err_stage_q <= STG_FREQ[1:0];
                    end
                end
                ST_DONE: begin
                    if (run) begin
                        state_q <= ST_GAP;
                        gap_q   <= '0;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_GAP: begin
                    if (!run) begin
                        state_q <= ST_IDLE;
                    end else if (gap_q == GAP_LAST) begin
                        state_q <= ST_MEM_CLR;
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                ST_ERR: begin
                    // err_stage keeps the last timed-out stage for inspection
                    if (err_clr) begin
                        state_q <= ST_IDLE;
                        error_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Status outputs are decodes of the state register.
    assign load_start   = (state_q == ST_LOAD);
    assign fft_start    = (state_q == ST_FFT);
    assign freq_start   = (state_q == ST_FREQ);
    assign result_valid = (state_q == ST_DONE);
    assign busy         = (state_q != ST_IDLE) && (state_q != ST_ERR);
    assign mem_rst_n    = in_stage || (state_q == ST_DONE) || (state_q == ST_GAP);
    assign stage        = stage_code(state_q);
    assign error        = error_q;
    assign err_stage    = err_stage_q;

    // Memory port mux: only the owning stage reaches the port; find_freq only reads.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        case (state_q)
            ST_LOAD: begin
                mem_addr  = load_addr;
                mem_wdata = load_wdata;
                mem_we    = load_we;
            end
            ST_FFT: begin
                mem_addr  = fft_addr;
                mem_wdata = fft_wdata;
                mem_we    = fft_we;
            end
            ST_FREQ: begin
                mem_addr = freq_addr;
            end
            default: begin
                mem_addr  = '0;
                mem_wdata = '0;
                mem_we    = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_tuner_sequencer.sv
// Bench for tuner_sequencer: stage engines modelled as fixed-delay responders,
// expected stage/port activity built as a per-cycle queue from the stage delays.
module tb_tuner_sequencer;

    localparam int AW = 11;
    localparam int DW = 10;

    logic          clk;
    logic          rst_n;
    logic          run;
    logic          single;
    logic          err_clr;
    logic          load_start, fft_start, freq_start;
    logic          load_done, fft_done, freq_done;
    logic [AW-1:0] load_addr, fft_addr, freq_addr;
    logic [DW-1:0] load_wdata, fft_wdata;
    logic          load_we, fft_we;
    logic          mem_rst_n;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [2:0]    stage;
    logic          busy;
    logic          result_valid;
    logic          error;
    logic [1:0]    err_stage;

    int n_cmp  = 0;
    int n_fail = 0;

    // Stage models: done rises in cycle (dly-1) of the stage; dly=0 means never.
    int   ld_dly, ff_dly, fq_dly;
    int   lcnt, fcnt, qcnt;
    logic stale;

    tuner_sequencer #(
        .ADDR_W(AW), .DATA_W(DW), .STAGE_TIMEOUT(16), .IDLE_GAP(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .single(single), .err_clr(err_clr),
        .load_start(load_start), .fft_start(fft_start), .freq_start(freq_start),
        .load_done(load_done), .fft_done(fft_done), .freq_done(freq_done),
        .load_addr(load_addr), .fft_addr(fft_addr), .freq_addr(freq_addr),
        .load_wdata(load_wdata), .fft_wdata(fft_wdata),
        .load_we(load_we), .fft_we(fft_we),
        .mem_rst_n(mem_rst_n), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .stage(stage), .busy(busy), .result_valid(result_valid),
        .error(error), .err_stage(err_stage)
    );

    // Clock and global time limit.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    // Stage engine models.
    always @(posedge clk) begin
        lcnt <= load_start ? lcnt + 1 : 0;
        fcnt <= fft_start  ? fcnt + 1 : 0;
        qcnt <= freq_start ? qcnt + 1 : 0;
    end
    assign load_done = stale | (load_start && ld_dly != 0 && lcnt == ld_dly - 1);
    assign fft_done  = stale | (fft_start  && ff_dly != 0 && fcnt == ff_dly - 1);
    assign freq_done = stale | (freq_start && fq_dly != 0 && qcnt == fq_dly - 1);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected memory port for a given display code.
    function automatic logic [31:0] exp_addr(input logic [2:0] c);
        case (c)
            3'd1:    return 32'(load_addr);
            3'd2:    return 32'(fft_addr);
            3'd3:    return 32'(freq_addr);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] c);
        case (c)
            3'd1:    return 32'(load_wdata);
            3'd2:    return 32'(fft_wdata);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] exp_we(input logic [2:0] c);
        case (c)
            3'd1:    return 32'(load_we);
            3'd2:    return 32'(fft_we);
            default: return 32'd0;
        endcase
    endfunction

    // Pulse single from IDLE and check the IDLE and MEM_CLR cycles.
    task automatic start_single();
        single = 1'b1;
        check("idle_stage", stage, 0);
        check("idle_mem_rst_n", mem_rst_n, 0);
        @(negedge clk);
        single = 1'b0;
        check("memclr_stage", stage, 0);
        check("memclr_mem_rst_n", mem_rst_n, 0);
        check("memclr_busy", busy, 1);
    endtask

    // Walk LOAD/FFT/FREQ/DONE against the queue built from the stage delays.
    task automatic walk(input int drop_at, output int rv_cnt, output int rv_idx);
        logic [2:0] exp_q[$];
        logic [2:0] code;
        int idx;
        for (int i = 0; i < ld_dly; i++) exp_q.push_back(3'd1);
        for (int i = 0; i < ff_dly; i++) exp_q.push_back(3'd2);
        for (int i = 0; i < fq_dly; i++) exp_q.push_back(3'd3);
        exp_q.push_back(3'd4);
        rv_cnt = 0;
        rv_idx = -1;
        idx    = 0;
        while (exp_q.size() != 0) begin
            if (idx == drop_at) run = 1'b0;
            @(negedge clk);
            code = exp_q.pop_front();
            check("stage", stage, code);
            check("starts", {load_start, fft_start, freq_start}, {code == 3'd1, code == 3'd2, code == 3'd3});
            check("mem_we", mem_we, exp_we(code));
            check("mem_addr", mem_addr, exp_addr(code));
            check("mem_wdata", mem_wdata, exp_wdata(code));
            check("mem_rst_n", mem_rst_n, 1);
            check("busy", busy, 1);
            check("error", error, 0);
            check("result_valid", result_valid, code == 3'd4);
            if (result_valid) begin
                rv_cnt++;
                rv_idx = idx;
            end
            idx++;
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_stage"}, stage, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_rv"}, result_valid, 0);
        check({tag, "_mem_we"}, mem_we, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_mem_rst_n"}, mem_rst_n, 0);
    endtask

    initial begin
        int rv_cnt, rv_idx;
        rst_n = 1'b0; run = 1'b0; single = 1'b0; err_clr = 1'b0; stale = 1'b0;
        load_addr = 11'h123; fft_addr = 11'h7FF; freq_addr = 11'h055;
        load_wdata = 10'h2AA; fft_wdata = 10'h155; load_we = 1'b1; fft_we = 1'b1;
        ld_dly = 5; ff_dly = 8; fq_dly = 3;

        // Reset values
        @(negedge clk);
        check("rst_stage", stage, 0);
        check("rst_starts", {load_start, fft_start, freq_start}, 0);
        check("rst_mem_rst_n", mem_rst_n, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_rv", result_valid, 0);
        check("rst_error", error, 0);
        check("rst_err_stage", err_stage, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Stale done outside its stage does nothing
        stale = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_idle("stale");
        end
        stale = 1'b0;

        // Single shot 5/8/3: result_valid on cycle 19 counting the single cycle as 1
        start_single();
        walk(-1, rv_cnt, rv_idx);
        check("single_rv_count", rv_cnt, 1);
        check("single_rv_cycle", rv_idx + 3, 19);
        @(negedge clk);
        check_idle("single_end");

        // Continuous: measurement, 4-cycle GAP, second measurement with run dropped in FFT
        ld_dly = $urandom_range(1, 15); ff_dly = $urandom_range(3, 12); fq_dly = $urandom_range(1, 15);
        run = 1'b1;
        check("run_idle_stage", stage, 0);
        @(negedge clk);
        check("run_memclr_stage", stage, 0);
        check("run_memclr_busy", busy, 1);
        walk(-1, rv_cnt, rv_idx);
        check("run1_rv_count", rv_cnt, 1);
        for (int g = 0; g < 4; g++) begin
            @(negedge clk);
            check("gap_stage", stage, 5);
            check("gap_busy", busy, 1);
            check("gap_mem_rst_n", mem_rst_n, 1);
            check("gap_rv", result_valid, 0);
        end
        @(negedge clk);
        check("run2_memclr_stage", stage, 0);
        check("run2_memclr_mem_rst_n", mem_rst_n, 0);
        check("run2_memclr_busy", busy, 1);
        walk(ld_dly + 1, rv_cnt, rv_idx);
        check("run2_rv_count", rv_cnt, 1);
        @(negedge clk);
        check_idle("run_drop_end");

        // fft_done never comes: ERR 15 cycles after FFT entry
        ld_dly = 4; ff_dly = 0; fq_dly = 3;
        start_single();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("err_load_stage", stage, 1);
        end
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check("err_fft_stage", stage, 2);
            check("err_fft_start", fft_start, 1);
        end
        @(negedge clk);
        check("err_stage_code", stage, 7);
        check("err_error", error, 1);
        check("err_err_stage", err_stage, 2);
        check("err_starts", {load_start, fft_start, freq_start}, 0);
        check("err_busy", busy, 0);
        check("err_mem_rst_n", mem_rst_n, 0);
        single = 1'b1;
        @(negedge clk);
        single = 1'b0;
        check("err_single_ignored", stage, 7);
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        check("err_run_ignored", stage, 7);
        check("err_sticky", error, 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("clr_stage", stage, 0);
        check("clr_error", error, 0);
        @(negedge clk);
        check_idle("clr_hold");

        // freq_done on the watchdog expiry cycle: done wins
        ld_dly = 3; ff_dly = 2; fq_dly = 15;
        start_single();
        walk(-1, rv_cnt, rv_idx);
        check("expiry_rv_count", rv_cnt, 1);
        @(negedge clk);
        check_idle("expiry_end");
        check("expiry_error", error, 0);

        // Reset mid-FFT
        ld_dly = 3; ff_dly = 10; fq_dly = 3;
        start_single();
        repeat (7) @(negedge clk);
        check("pre_rst_stage", stage, 2);
        #2 rst_n = 1'b0;
        #1;
        check("arst_stage", stage, 0);
        check("arst_starts", {load_start, fft_start, freq_start}, 0);
        check("arst_mem_rst_n", mem_rst_n, 0);
        check("arst_mem_we", mem_we, 0);
        check("arst_mem_addr", mem_addr, 0);
        check("arst_rv", result_valid, 0);
        check("arst_busy", busy, 0);
        @(negedge clk);
        check("arst_hold_rv", result_valid, 0);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_idle("post_rst");
        end
        start_single();
        walk(-1, rv_cnt, rv_idx);
        check("post_rst_rv_count", rv_cnt, 1);
        @(negedge clk);

        // Randomized single-shot measurements
        for (int t = 0; t < 6; t++) begin
            ld_dly = $urandom_range(1, 15); ff_dly = $urandom_range(1, 15); fq_dly = $urandom_range(1, 15);
            freq_addr = AW'($urandom_range(0, 2047));
            load_wdata = DW'($urandom_range(0, 1023));
            fft_wdata  = DW'($urandom_range(0, 1023));
            load_we = 1'($urandom_range(0, 1));
            fft_we  = 1'($urandom_range(0, 1));
            start_single();
            walk(-1, rv_cnt, rv_idx);
            check("rand_rv_count", rv_cnt, 1);
            repeat ($urandom_range(1, 3)) begin
                @(negedge clk);
                check_idle("rand_idle");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
